// File: rtl/bla_pkg.sv
// Shared types and sizes for the nibble-serial 16-bit subtractor.
package bla_pkg;
   localparam int WIDTH   = 16;
   localparam int NIB     = 4;
   localparam int NIBBLES = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/bla_sub_serial_bla4.sv
// 4-bit borrow-lookahead subtractor slice: d = a - b - bin, bout = borrow out of bit 3.
module bla4
   import bla_pkg::*;
(
   input  logic [NIB-1:0] a,
   input  logic [NIB-1:0] b,
   input  logic           bin,
   output logic [NIB-1:0] d,
   output logic           bout
);

   logic [NIB-1:0] w_g;
   logic [NIB-1:0] w_p;
   logic [NIB:0]   w_br;

   // generate: a_i=0,b_i=1 always borrows; propagate: equal bits pass the incoming borrow
   assign w_g = ~a & b;
   assign w_p = ~(a ^ b);

   assign w_br[0] = bin;
   assign w_br[1] = w_g[0] | (w_p[0] & bin);
   assign w_br[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & bin);
   assign w_br[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & bin);
   assign w_br[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & bin);

   assign d    = a ^ b ^ w_br[NIB-1:0];
   assign bout = w_br[NIB];

endmodule

// File: rtl/bla_sub_serial.sv
// Nibble-serial 16-bit subtractor: one 4-bit lookahead slice reused over four CALC cycles.
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   CALC  | one nibble per cycle, LSB first
//   DONE  | result held until out_ready
module bla_sub_serial
   import bla_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero
);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_diff;
   logic [1:0]       r_cnt;
   logic             r_br;
   logic             r_zero;

   logic [3:0]       w_base;
   logic             w_last;
   logic [NIB-1:0]   w_nib_a;
   logic [NIB-1:0]   w_nib_b;
   logic [NIB-1:0]   w_nib_d;
   logic             w_nib_bo;

   assign w_base  = {r_cnt, 2'b00};
   assign w_last  = (r_cnt == 2'(NIBBLES - 1));
   assign w_nib_a = r_a[w_base +: NIB];
   assign w_nib_b = r_b[w_base +: NIB];

   bla4 u_bla4 (
      .a    (w_nib_a),
      .b    (w_nib_b),
      .bin  (r_br),
      .d    (w_nib_d),
      .bout (w_nib_bo)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_next = CALC;
         CALC:    if (w_last)    w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_diff <= '0;
         r_cnt  <= '0;
         r_br   <= 1'b0;
         r_zero <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a   <= a;
                  r_b   <= b;
                  r_br  <= bin;
                  r_cnt <= '0;
               end
            end
            CALC: begin
               r_diff[w_base +: NIB] <= w_nib_d;
               r_br                  <= w_nib_bo;
               r_cnt                 <= r_cnt + 2'd1;
               // lower three nibbles are already in r_diff when the top one lands
               if (w_last)
                  r_zero <= (w_nib_d == '0) && (r_diff[WIDTH-NIB-1:0] == '0);
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign diff      = r_diff;
   assign bout      = r_br;
   assign zero      = r_zero;

endmodule

// File: tb/tb_bla_sub_serial.sv
// Scoreboard bench for bla_sub_serial: driver pushes model results, negedge monitor pops on handshake.
module tb_bla_sub_serial;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] diff;
   logic        bout;
   logic        zero;

   always #5 clk = ~clk;

   bla_sub_serial dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .zero      (zero)
   );

   typedef struct packed {
      logic [15:0] d;
      logic        bo;
      logic        z;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   m_chk = 0;
   int   m_err = 0;

   // 17-bit arithmetic: the top bit of the widened difference is the borrow
   function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
      logic [16:0] r;
      exp_t        e;
      r    = {1'b0, x} - {1'b0, y} - {16'd0, c};
      e.d  = r[15:0];
      e.bo = r[16];
      e.z  = (r[15:0] == 16'h0000);
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         m_chk++;
         if (exp_q.size() == 0) begin
            m_err++;
            $display("FAIL unexpected_result actual diff=%h bout=%b zero=%b required none", diff, bout, zero);
         end else begin
            e = exp_q.pop_front();
            if ({diff, bout, zero} !== e) begin
               m_err++;
               $display("FAIL result actual diff=%h bout=%b zero=%b required diff=%h bout=%b zero=%b",
                        diff, bout, zero, e.d, e.bo, e.z);
            end
         end
      end
   end

   task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin, input int hold);
      int          n;
      logic [15:0] sd;
      logic        sb;
      logic        sz;
      a         = ta;
      b         = tb_v;
      bin       = tbin;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept_wait", 32'(n < 50), 32'd1);
      @(posedge clk);
      exp_q.push_back(model(ta, tb_v, tbin));
      #1;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
         in_valid = 1'($urandom);
         a        = 16'($urandom);
         b        = 16'($urandom);
         bin      = 1'($urandom);
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, 32'd4);
      sd = diff;
      sb = bout;
      sz = zero;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom);
         @(posedge clk); #1;
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         chk("hold_stable", {14'd0, diff, bout, zero}, {14'd0, sd, sb, sz});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_idle", {30'd0, in_ready, out_valid}, 32'd2);
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      a         = 16'h1234;
      b         = 16'h0001;
      bin       = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_diff", {16'd0, diff}, 32'h0);
      chk("rst_bout", {31'd0, bout}, 32'd0);
      chk("rst_zero", {31'd0, zero}, 32'd0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("idle_quiet", {30'd0, in_ready, out_valid}, 32'd2);
      end

      send(16'h1234, 16'h0234, 1'b0, 0);
      send(16'h0000, 16'h0001, 1'b0, 1);
      send(16'h8000, 16'h8000, 1'b1, 0);
      send(16'hABCD, 16'hABCD, 1'b0, 2);
      send(16'h5A5A, 16'h1234, 1'b1, 3);
      send(16'hFFFF, 16'h0000, 1'b1, 0);

      // abort during the second CALC cycle: nothing must come out
      a        = 16'h1111;
      b        = 16'h2222;
      bin      = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_diff", {16'd0, diff}, 32'h0);
      chk("abort_bout", {31'd0, bout}, 32'd0);
      repeat (6) begin
         @(posedge clk); #1;
         chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
      end
      out_ready = 1'b0;
      send(16'h00FF, 16'h000F, 1'b0, 1);

      for (int i = 0; i < 1000; i++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         ra = 16'($urandom);
         rb = 16'($urandom);
         if ($urandom_range(0, 7) == 0) rb = ra;
         if ($urandom_range(0, 15) == 0) ra = 16'h0000;
         if ($urandom_range(0, 15) == 0) rb = 16'hFFFF;
         send(ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
      end

      repeat (2) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk + m_chk, n_err + m_err);
      $finish;
   end

endmodule

// File: doc/bla_sub_serial.md
BLA_SUB_SERIAL -- requirements
Module: bla_sub_serial

Interface
REQ-001 Parameters: none; width fixed at 16-bit operands, processed as four 4-bit nibbles.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  operand set a/b/bin present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  16  minuend.
REQ-008 b  input  16  subtrahend.
REQ-009 bin  input  1  borrow-in.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 diff  output  16  (a - b - bin) mod 2^16.
REQ-013 bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).
REQ-014 zero  output  1  1 iff diff == 0.

Function
REQ-015 FSM SHALL have states IDLE, CALC, DONE.
REQ-016 IDLE: in_ready=1; on in_valid&&in_ready, register a, b, bin, clear nibble counter, go to CALC.
REQ-017 CALC: each cycle, subtract nibble k (LSB first, k=0..3) through the 4-bit borrow-lookahead slice using the registered borrow (bin for k=0), write the nibble into diff[4k+3:4k], register slice borrow-out; after k=3 go to DONE.
REQ-018 Borrow-lookahead slice: g_i = ~a_i & b_i, p_i = ~(a_i ^ b_i), d_i = a_i ^ b_i ^ br_i, all borrows br_1..br_4 in two-level lookahead form, no ripple.
REQ-019 Latency: acceptance edge T, out_valid=1 from edge T+4 (four CALC cycles).
REQ-020 DONE: out_valid=1; diff, bout, zero stable and held while out_ready=0.
REQ-021 DONE with out_ready=1: go to IDLE; in_ready reasserts the following cycle (no same-cycle accept on release).
REQ-022 in_ready=0 in CALC and DONE; in_valid is ignored there and input changes do not affect the result.
REQ-023 zero and bout SHALL be valid whenever out_valid=1; their values at other times are undefined but must not be X after reset.
REQ-024 Wrap-around: results wrap mod 2^16 with bout=1 (e.g. 0x0000-0x0001 = 0xFFFF).

Reset
REQ-025 rst_n=0 at a clock edge: state to IDLE; in_ready=1, out_valid=0, diff=0x0000, bout=0, zero=0, counter=0, borrow register=0.
REQ-026 Reset mid-CALC or in DONE SHALL abort the operation and discard the partial result, with no out_valid pulse.
REQ-027 Reset has priority over all handshakes in the same cycle.

Structure
REQ-028 Shared package bla_pkg SHALL hold the state enum, WIDTH=16, NIB=4 and NIBBLES=4.
REQ-029 One sub-module bla4: combinational 4-bit borrow-lookahead subtractor (a, b, bin -> d[3:0], bout), instantiated once and reused per cycle.
REQ-030 No combinational path from in_valid or out_ready to in_ready or out_valid.

Verification
REQ-031 a=0x1234, b=0x0234, bin=0 -> out_valid at T+4, diff=0x1000, bout=0, zero=0.
REQ-032 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1; a=0x8000, b=0x8000, bin=1 -> diff=0xFFFF, bout=1.
REQ-033 a=0xABCD, b=0xABCD, bin=0 -> diff=0x0000, zero=1, bout=0.
REQ-034 Backpressure: out_ready=0 for 3 cycles in DONE -> diff, bout and zero unchanged; in_ready=0 throughout; IDLE one cycle after out_ready=1.
REQ-035 Reset: rst_n=0 during CALC cycle 2 -> next cycle IDLE, in_ready=1, out_valid=0, diff=0x0000; a following op 0x00FF-0x000F -> 0x00F0.
REQ-036 Random: 1000 random a/b/bin vectors checked against a 17-bit reference model.
